hub75_rx: RTL and testbench

- HUB75 panel-side receiver/monitor: samples a HUB75 bus (r0,g0,b0,r1,g1,b1, addr, clk, latch, oe) exactly as a panel's shift registers would.
- Captures one row of shifted pixels per latch pulse and replays the row as a valid/ready pixel stream with the row address.
- Uses: loopback checking of the LED panel driver, and chaining/monitoring of panel traffic.
- Ping-pong row buffers: capture of row N+1 proceeds while row N streams out.

---
 rtl/hub75_rx.sv | 199 +++++++++++++++++++
 tb/tb_hub75_rx.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver. Samples the bus the way a panel's shift registers would, captures
// one row per latch pulse into a ping-pong buffer, and replays it as a valid/ready pixel stream.
module hub75_rx #(
  parameter int unsigned COLS        = 64,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hub_r0,
  input  logic                     hub_g0,
  input  logic                     hub_b0,
  input  logic                     hub_r1,
  input  logic                     hub_g1,
  input  logic                     hub_b1,
  input  logic [ADDR_W-1:0]        hub_addr,
  input  logic                     hub_clk,
  input  logic                     hub_lat,
  input  logic                     hub_oe,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [5:0]               pix_data,
  output logic [$clog2(COLS)-1:0]  pix_col,
  output logic [ADDR_W-1:0]        pix_row,
  output logic                     pix_last,
  output logic                     row_done,
  output logic                     oe_active,
  input  logic                     err_clr,
  output logic                     err_overrun,
  output logic                     err_short,
  output logic                     err_drop
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned NW = $clog2(COLS + 1);
  localparam int unsigned SW = 6 + ADDR_W + 3;
  localparam logic [NW-1:0] COLS_N = NW'(COLS);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StStream = 2'd2;

  // All bus inputs share one chain so data, address and strobes stay aligned. The output
  // enable is stored inverted so the cleared chain reads as "panel dark".
  logic [SW-1:0] sync_in;
  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] synced;

  assign sync_in = {~hub_oe, hub_lat, hub_clk, hub_addr,
                    hub_b1, hub_g1, hub_r1, hub_b0, hub_g0, hub_r0};
  assign synced  = sync_q[SYNC_STAGES-1];

  logic [5:0]        s_data;
  logic [ADDR_W-1:0] s_addr;
  logic              s_clk, s_lat;

  assign s_data    = synced[5:0];
  assign s_addr    = synced[6 +: ADDR_W];
  assign s_clk     = synced[6 + ADDR_W];
  assign s_lat     = synced[7 + ADDR_W];
  assign oe_active = synced[8 + ADDR_W];

  // Synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sync_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic clk_prev_q, lat_prev_q;
  logic clk_rise, lat_rise;

  // Delayed copies of the synced strobes for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_q <= 1'b0;
      lat_prev_q <= 1'b0;
    end else begin
      clk_prev_q <= s_clk;
      lat_prev_q <= s_lat;
    end
  end

  assign clk_rise = s_clk & ~clk_prev_q;
  assign lat_rise = s_lat & ~lat_prev_q;

  logic [NW-1:0] wr_cnt_q, cnt_after;
  logic          wr_bank_q;
  logic [1:0]    state_q, state_d;
  logic          busy, do_write, do_swap;
  logic          ev_overrun, ev_short, ev_drop;

  // A shift clock coinciding with the latch is counted before the latch decision.
  assign busy       = (state_q != StIdle);
  assign do_write   = clk_rise && (wr_cnt_q != COLS_N);
  assign cnt_after  = do_write ? wr_cnt_q + NW'(1) : wr_cnt_q;
  assign ev_overrun = clk_rise && (wr_cnt_q == COLS_N);
  assign ev_short   = lat_rise && (cnt_after < COLS_N);
  assign do_swap    = lat_rise && !busy && (cnt_after != '0);
  assign ev_drop    = lat_rise && busy;

  logic [5:0] mem [2][COLS];

  // Row buffer write port; the write bank is never the bank being streamed.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_bank_q][wr_cnt_q[CW-1:0]] <= s_data;
  end

  // Write counter and bank selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else begin
      wr_cnt_q <= lat_rise ? '0 : cnt_after;
      if (do_swap) wr_bank_q <= ~wr_bank_q;
    end
  end

  logic              rd_bank_q, rd_bank_d;
  logic [NW-1:0]     len_q, len_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic              last_beat;

  assign last_beat = (NW'(col_q) == len_q - NW'(1));

  // Output stream next state. StLoad is the row_done cycle between swap and first beat.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    len_d     = len_q;
    row_d     = row_q;
    col_d     = col_q;
    case (state_q)
      StIdle: begin
        if (do_swap) begin
          state_d   = StLoad;
          rd_bank_d = wr_bank_q;
          len_d     = cnt_after;
          row_d     = s_addr;
          col_d     = '0;
        end
      end
      StLoad:   state_d = StStream;
      StStream: begin
        if (pix_ready) begin
          if (last_beat) begin
            state_d = StIdle;
            col_d   = '0;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  // Output stream state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rd_bank_q <= 1'b0;
      len_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      len_q     <= len_d;
      row_q     <= row_d;
      col_q     <= col_d;
    end
  end

  assign row_done  = (state_q == StLoad);
  assign pix_valid = (state_q == StStream);
  assign pix_data  = pix_valid ? mem[rd_bank_q][col_q] : 6'd0;
  assign pix_col   = col_q;
  assign pix_row   = row_q;
  assign pix_last  = pix_valid && last_beat;

  logic [2:0] err_q;

  // Sticky errors; a new event in the clear cycle wins.
  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= (err_q & ~{3{err_clr}}) | {ev_drop, ev_short, ev_overrun};
  end

  assign err_overrun = err_q[0];
  assign err_short   = err_q[1];
  assign err_drop    = err_q[2];

endmodule

// File: tb/tb_hub75_rx.sv
// Self-checking bench for hub75_rx: random rows shifted over the HUB75 pins, compared against a
// queue model of what a row should look like when it is replayed.
module tb_hub75_rx;
  localparam int COLS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hub_r0 = 0, hub_g0 = 0, hub_b0 = 0, hub_r1 = 0, hub_g1 = 0, hub_b1 = 0;
  logic [4:0] hub_addr = '0;
  logic       hub_clk = 0, hub_lat = 0, hub_oe = 1;
  logic       pix_valid, pix_ready = 0, pix_last, row_done, oe_active;
  logic [5:0] pix_data, pix_col;
  logic [4:0] pix_row;
  logic       err_clr = 0, err_overrun, err_short, err_drop;

  hub75_rx #(.COLS(COLS), .ADDR_W(5), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_addr(hub_addr), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_col(pix_col),
    .pix_row(pix_row), .pix_last(pix_last), .row_done(row_done), .oe_active(oe_active),
    .err_clr(err_clr), .err_overrun(err_overrun), .err_short(err_short), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;

  always @(posedge clk) if (row_done === 1'b1) rd_cnt <= rd_cnt + 1;

  // Model: pixels shifted since the last latch, and the row expected on the stream.
  logic [5:0] sent [$];
  logic [5:0] exp_pix [COLS];
  int         exp_n;
  logic [4:0] exp_row;

  // Observations from the stream.
  logic [5:0] obs_data [256];
  logic [5:0] obs_col [256];
  logic [4:0] obs_row [256];
  logic       obs_last [256];
  int         obs_n, stall_bad;

  task automatic shift_pixel(input logic [5:0] d);
    {hub_b1, hub_g1, hub_r1, hub_b0, hub_g0, hub_r0} = d;
    sent.push_back(d);
    hub_clk = 1;
    @(negedge clk);
    hub_clk = 0;
    @(negedge clk);
  endtask

  task automatic shift_n(input int n, input bit ramp);
    for (int k = 0; k < n; k++) shift_pixel(ramp ? 6'(k) : 6'($urandom()));
  endtask

  // keep=1: the model knows the output bank is busy (or the row is empty), so the row is lost.
  task automatic do_latch(input logic [4:0] a, input bit keep);
    if (!keep) begin
      exp_n = (sent.size() > COLS) ? COLS : sent.size();
      for (int k = 0; k < exp_n; k++) exp_pix[k] = sent[k];
      exp_row = a;
    end
    sent.delete();
    hub_addr = a;
    hub_lat = 1;
    @(negedge clk);
    hub_lat = 0;
  endtask

  // Collects beats until pix_last or limit; mode 0 ready high, 1 toggling, 2 random.
  task automatic receive_row(input int limit, input int mode);
    logic [17:0] held;
    bit stalled;
    obs_n = 0; stall_bad = 0; stalled = 0; held = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case (mode)
        0:       pix_ready = 1;
        1:       pix_ready = ((cyc % 2) == 0);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      if (pix_valid && stalled && {pix_data, pix_col, pix_row, pix_last} !== held)
        stall_bad++;
      if (pix_valid && pix_ready) begin
        obs_data[obs_n] = pix_data; obs_col[obs_n] = pix_col;
        obs_row[obs_n] = pix_row; obs_last[obs_n] = pix_last;
        obs_n++;
        stalled = 0;
        if (pix_last || obs_n >= limit) begin
          @(negedge clk);
          return;
        end
      end else begin
        stalled = pix_valid;
        held = {pix_data, pix_col, pix_row, pix_last};
      end
      @(negedge clk);
    end
  endtask

  task automatic clear_errs();
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    total++;
    if ({pix_valid, row_done, pix_data, pix_col, pix_row, pix_last, oe_active,
         err_overrun, err_short, err_drop} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b rd=%b d=%h c=%0d r=%0d l=%b oe=%b err=%b%b%b want all 0",
               pix_valid, row_done, pix_data, pix_col, pix_row, pix_last, oe_active,
               err_drop, err_short, err_overrun);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_oe();
    hub_oe = 0;
    repeat (3) @(negedge clk);
    total++;
    if (oe_active !== 1'b1) begin bad++; $display("FAIL oe_on got %b want 1", oe_active); end
    hub_oe = 1;
    repeat (3) @(negedge clk);
    total++;
    if (oe_active !== 1'b0) begin bad++; $display("FAIL oe_off got %b want 0", oe_active); end
  endtask

  task automatic test_basic();
    int rd0;
    rd0 = rd_cnt;
    pix_ready = 1;
    shift_n(64, 1);
    do_latch(5'd5, 0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({row_done, pix_valid} !== 2'b10) begin
      bad++; $display("FAIL basic_latency_rd got rd=%b v=%b want rd=1 v=0", row_done, pix_valid);
    end
    @(negedge clk);
    total++;
    if (pix_valid !== 1'b1) begin bad++; $display("FAIL basic_latency_v got %b want 1", pix_valid); end
    receive_row(1000, 0);
    total++;
    if (obs_n !== 64) begin bad++; $display("FAIL basic_beats got %0d want 64", obs_n); end
    for (int k = 0; k < exp_n; k++) begin
      total++;
      if ({obs_data[k], obs_col[k], obs_row[k], obs_last[k]} !==
          {exp_pix[k], 6'(k), 5'd5, (k == 63)}) begin
        bad++;
        $display("FAIL basic_beat%0d got d=%h c=%0d r=%0d l=%b want d=%h c=%0d r=5 l=%b", k,
                 obs_data[k], obs_col[k], obs_row[k], obs_last[k], exp_pix[k], k, k == 63);
      end
    end
    total++;
    if (rd_cnt - rd0 !== 1) begin bad++; $display("FAIL basic_row_done got %0d want 1", rd_cnt - rd0); end
    total++;
    if ({err_drop, err_short, err_overrun} !== 3'b000) begin
      bad++; $display("FAIL basic_errs got %b%b%b want 000", err_drop, err_short, err_overrun);
    end
  endtask

  task automatic test_backpressure();
    shift_n(64, 0);
    do_latch(5'($urandom()), 0);
    receive_row(1000, 1);
    total++;
    if (obs_n !== 64) begin bad++; $display("FAIL bp_beats got %0d want 64", obs_n); end
    total++;
    if (stall_bad !== 0) begin bad++; $display("FAIL bp_stable got %0d changes want 0", stall_bad); end
    for (int k = 0; k < exp_n; k++) begin
      total++;
      if ({obs_data[k], obs_col[k], obs_row[k], obs_last[k]} !==
          {exp_pix[k], 6'(k), exp_row, (k == exp_n - 1)}) begin
        bad++;
        $display("FAIL bp_beat%0d got d=%h c=%0d r=%0d l=%b want d=%h c=%0d r=%0d", k,
                 obs_data[k], obs_col[k], obs_row[k], obs_last[k], exp_pix[k], k, exp_row);
      end
    end
  endtask

  task automatic test_overrun();
    clear_errs();
    shift_n(70, 0);
    do_latch(5'($urandom()), 0);
    receive_row(1000, 2);
    total++;
    if (obs_n !== 64) begin bad++; $display("FAIL ovr_beats got %0d want 64", obs_n); end
    for (int k = 0; k < exp_n; k++) begin
      total++;
      if ({obs_data[k], obs_col[k], obs_row[k], obs_last[k]} !==
          {exp_pix[k], 6'(k), exp_row, (k == exp_n - 1)}) begin
        bad++;
        $display("FAIL ovr_beat%0d got d=%h c=%0d l=%b want d=%h c=%0d", k,
                 obs_data[k], obs_col[k], obs_last[k], exp_pix[k], k);
      end
    end
    total++;
    if ({err_drop, err_short, err_overrun} !== 3'b001) begin
      bad++; $display("FAIL ovr_flag got %b%b%b want 001", err_drop, err_short, err_overrun);
    end
    clear_errs();
    total++;
    if (err_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got %b want 0", err_overrun); end
  endtask

  task automatic test_short();
    int rd0;
    bit seen;
    clear_errs();
    shift_n(10, 0);
    do_latch(5'($urandom()), 0);
    receive_row(1000, 0);
    total++;
    if (obs_n !== 10) begin bad++; $display("FAIL short_beats got %0d want 10", obs_n); end
    for (int k = 0; k < exp_n; k++) begin
      total++;
      if ({obs_data[k], obs_col[k], obs_row[k], obs_last[k]} !==
          {exp_pix[k], 6'(k), exp_row, (k == 9)}) begin
        bad++;
        $display("FAIL short_beat%0d got d=%h c=%0d l=%b want d=%h c=%0d l=%b", k,
                 obs_data[k], obs_col[k], obs_last[k], exp_pix[k], k, k == 9);
      end
    end
    total++;
    if (err_short !== 1'b1) begin bad++; $display("FAIL short_flag got %b want 1", err_short); end
    clear_errs();
    rd0 = rd_cnt;
    seen = 0;
    do_latch(5'd3, 1);
    repeat (8) begin
      @(negedge clk);
      if (pix_valid === 1'b1) seen = 1;
    end
    total++;
    if ({seen, err_short} !== 2'b01 || rd_cnt != rd0) begin
      bad++;
      $display("FAIL short_empty got valid_seen=%b short=%b row_done=%0d want 0 1 0",
               seen, err_short, rd_cnt - rd0);
    end
  endtask

  task automatic test_drop();
    logic [5:0] a_pix [COLS];
    logic [4:0] a_row;
    int rd0;
    clear_errs();
    rd0 = rd_cnt;
    pix_ready = 0;
    shift_n(64, 0);
    do_latch(5'($urandom()), 0);
    a_pix = exp_pix; a_row = exp_row;
    shift_n(64, 0);
    do_latch(5'($urandom()), 1);
    repeat (4) @(negedge clk);
    total++;
    if ({err_drop, err_short, err_overrun} !== 3'b100) begin
      bad++; $display("FAIL drop_flag got %b%b%b want 100", err_drop, err_short, err_overrun);
    end
    receive_row(1000, 0);
    pix_ready = 0;
    total++;
    if (obs_n !== 64) begin bad++; $display("FAIL drop_a_beats got %0d want 64", obs_n); end
    for (int k = 0; k < COLS; k++) begin
      total++;
      if ({obs_data[k], obs_col[k], obs_row[k]} !== {a_pix[k], 6'(k), a_row}) begin
        bad++;
        $display("FAIL drop_a_beat%0d got d=%h c=%0d r=%0d want d=%h c=%0d r=%0d", k,
                 obs_data[k], obs_col[k], obs_row[k], a_pix[k], k, a_row);
      end
    end
    repeat (6) @(negedge clk);
    total++;
    if (pix_valid !== 1'b0) begin bad++; $display("FAIL drop_b_gone got %b want 0", pix_valid); end
    shift_n(64, 0);
    do_latch(5'($urandom()), 0);
    receive_row(1000, 2);
    total++;
    if (obs_n !== 64) begin bad++; $display("FAIL drop_c_beats got %0d want 64", obs_n); end
    for (int k = 0; k < exp_n; k++) begin
      total++;
      if ({obs_data[k], obs_col[k], obs_row[k], obs_last[k]} !==
          {exp_pix[k], 6'(k), exp_row, (k == 63)}) begin
        bad++;
        $display("FAIL drop_c_beat%0d got d=%h c=%0d r=%0d want d=%h c=%0d r=%0d", k,
                 obs_data[k], obs_col[k], obs_row[k], exp_pix[k], k, exp_row);
      end
    end
    total++;
    if (rd_cnt - rd0 !== 2) begin bad++; $display("FAIL drop_row_done got %0d want 2", rd_cnt - rd0); end
  endtask

  task automatic test_reset_midstream();
    shift_n(70, 0);
    do_latch(5'($urandom()), 0);
    receive_row(20, 0);
    rst = 1;
    @(negedge clk);
    total++;
    if ({pix_valid, err_drop, err_short, err_overrun} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_mid got v=%b err=%b%b%b want 0 000", pix_valid, err_drop, err_short,
               err_overrun);
    end
    rst = 0;
    @(negedge clk);
    shift_n(64, 0);
    do_latch(5'($urandom()), 0);
    receive_row(1000, 0);
    total++;
    if (obs_n !== 64) begin bad++; $display("FAIL rst_fresh_beats got %0d want 64", obs_n); end
    for (int k = 0; k < exp_n; k++) begin
      total++;
      if ({obs_data[k], obs_col[k], obs_row[k], obs_last[k]} !==
          {exp_pix[k], 6'(k), exp_row, (k == 63)}) begin
        bad++;
        $display("FAIL rst_fresh_beat%0d got d=%h c=%0d r=%0d want d=%h c=%0d r=%0d", k,
                 obs_data[k], obs_col[k], obs_row[k], exp_pix[k], k, exp_row);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [5:0] d;
    shift_n(5, 0);
    d = 6'($urandom());
    {hub_b1, hub_g1, hub_r1, hub_b0, hub_g0, hub_r0} = d;
    sent.push_back(d);
    hub_clk = 1;
    do_latch(5'($urandom()), 0);
    hub_clk = 0;
    receive_row(1000, 0);
    total++;
    if (obs_n !== 6) begin bad++; $display("FAIL same_beats got %0d want 6", obs_n); end
    for (int k = 0; k < exp_n; k++) begin
      total++;
      if ({obs_data[k], obs_col[k], obs_row[k], obs_last[k]} !==
          {exp_pix[k], 6'(k), exp_row, (k == 5)}) begin
        bad++;
        $display("FAIL same_beat%0d got d=%h c=%0d l=%b want d=%h c=%0d l=%b", k,
                 obs_data[k], obs_col[k], obs_last[k], exp_pix[k], k, k == 5);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_oe();
    test_basic();
    test_backpressure();
    test_overrun();
    test_short();
    test_drop();
    test_reset_midstream();
    test_same_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
